// File: rtl/dpll_config_slew.sv
// dpll_config_slew
// ----------------------------------------------------------------------------
// busClk-domain register bank that drives the digital PLL's quasi-static
// controls. Processor writes land in staging registers. A commit makes them
// live together. With the slew engine built in, the live centerFreq ramps
// toward the committed target in programmable steps instead of jumping.
//
// Build option:
//   DPLL_FREQ_SLEW_EN  defined   -> slew engine (IDLE/SLEW machine, SLEW_CFG).
//                      undefined -> every commit applies centerFreq at once,
//                                   slewBusy is tied low, SLEW_CFG reads 0.
//
// Ports:
//   busClk          in   clock for all logic
//   reset           in   synchronous, active-high reset
//   addr[12:0]      in   bus address; block select addr[12:5], offset addr[4:2]
//   dataIn[31:0]    in   write data
//   wr0..wr3        in   byte-lane write strobes ([7:0] .. [31:24])
//   dataOut[31:0]   out  combinational read data
//   centerFreq      out  live NCO center frequency
//   loopGain        out  live loop gain
//   feedbackDivider out  live feedback divider
//   slewBusy        out  high while a ramp is in progress
//   configStrobe    out  one-cycle pulse, aligned with any live output change
//
// Register map (word offset):
//   0 FREQ_STAGE  rw  byte-writable
//   1 GAIN_STAGE  rw  loopGain [4:0] (wr0), feedbackDivider [23:16] (wr2)
//   2 CONTROL     wo  wr0 only; bit0 commit, bit1 abort (abort wins)
//   3 SLEW_CFG    rw  byte-writable; step [15:0], interval [31:16]
//   4 STATUS      ro  {29'b0, doneSticky, slewBusy, 1'b0}
//   5 LIVE_FREQ   ro  live centerFreq
// ----------------------------------------------------------------------------
module dpll_config_slew #(
  parameter logic [7:0]  SPACE_BASE = 8'h00,
  parameter logic [31:0] FREQ_RESET = 32'h0000_0000,
  parameter logic [7:0]  DIV_RESET  = 8'h01
) (
  input  logic        busClk,
  input  logic        reset,
  input  logic [12:0] addr,
  input  logic [31:0] dataIn,
  input  logic        wr0,
  input  logic        wr1,
  input  logic        wr2,
  input  logic        wr3,
  output logic [31:0] dataOut,
  output logic [31:0] centerFreq,
  output logic [4:0]  loopGain,
  output logic [7:0]  feedbackDivider,
  output logic        slewBusy,
  output logic        configStrobe
);

  // --------------------------------------------------------------------------
  // Address decode and byte-lane mask
  // --------------------------------------------------------------------------
  logic        blockSel;
  logic [2:0]  offset;
  logic [3:0]  byteEn;
  logic        anyWr;
  logic [31:0] wrMask;
  logic        wrFreq;
  logic        wrGain;
  logic        commitReq;

  assign blockSel = (addr[12:5] == SPACE_BASE);
  assign offset   = addr[4:2];
  assign byteEn   = {wr3, wr2, wr1, wr0};
  assign anyWr    = |byteEn;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : genLaneMask
      assign wrMask[gi*8 +: 8] = {8{byteEn[gi]}};
    end
  endgenerate

  assign wrFreq = blockSel && anyWr && (offset == 3'd0);
  assign wrGain = blockSel && anyWr && (offset == 3'd1);

  // Commit only counts when abort is not requested in the same write.
  assign commitReq = blockSel && wr0 && (offset == 3'd2) && dataIn[0] && !dataIn[1];

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [31:0] freqStageReg, freqStageNext;
  logic [4:0]  gainStageReg, gainStageNext;
  logic [7:0]  divStageReg,  divStageNext;
  logic [31:0] freqLiveReg,  freqLiveNext;
  logic [4:0]  gainLiveReg,  gainLiveNext;
  logic [7:0]  divLiveReg,   divLiveNext;
  logic        doneStickyReg, doneStickyNext;
  logic        strobeReg,    strobeNext;

`ifdef DPLL_FREQ_SLEW_EN
  typedef enum logic {IDLE, SLEW} stateT;

  stateT       stateReg, stateNext;
  logic [15:0] stepReg, stepNext;
  logic [15:0] intervalReg, intervalNext;
  logic [15:0] intervalCntReg, intervalCntNext;
  logic [31:0] targetReg, targetNext;
  logic        wrSlew;
  logic        abortReq;
  logic [31:0] stepExt;
  logic [31:0] slewValue;

  assign wrSlew   = blockSel && anyWr && (offset == 3'd3);
  assign abortReq = blockSel && wr0 && (offset == 3'd2) && dataIn[1];
  assign stepExt  = {16'h0000, stepReg};

  // Next live value one step toward the target. The distance is compared
  // against the step before adding/subtracting, so the result clamps onto
  // the target and can never wrap past 0 or 2^32-1.
  always_comb begin
    slewValue = targetReg;
    if (targetReg > freqLiveReg) begin
      if ((targetReg - freqLiveReg) > stepExt) begin
        slewValue = freqLiveReg + stepExt;
      end
    end else begin
      if ((freqLiveReg - targetReg) > stepExt) begin
        slewValue = freqLiveReg - stepExt;
      end
    end
  end

  assign slewBusy = (stateReg == SLEW);
`else
  assign slewBusy = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    freqStageNext  = freqStageReg;
    gainStageNext  = gainStageReg;
    divStageNext   = divStageReg;
    freqLiveNext   = freqLiveReg;
    gainLiveNext   = gainLiveReg;
    divLiveNext    = divLiveReg;
    doneStickyNext = doneStickyReg;
`ifdef DPLL_FREQ_SLEW_EN
    stateNext       = stateReg;
    stepNext        = stepReg;
    intervalNext    = intervalReg;
    intervalCntNext = intervalCntReg;
    targetNext      = targetReg;
`endif

    // Staging writes
    if (wrFreq) begin
      freqStageNext = (freqStageReg & ~wrMask) | (dataIn & wrMask);
    end
    if (wrGain) begin
      if (wr0) gainStageNext = dataIn[4:0];
      if (wr2) divStageNext  = dataIn[23:16];
    end

    // Gains go live on every commit regardless of slew state.
    if (commitReq) begin
      gainLiveNext   = gainStageReg;
      divLiveNext    = divStageReg;
      doneStickyNext = 1'b0;
    end

`ifdef DPLL_FREQ_SLEW_EN
    if (wrSlew) begin
      {intervalNext, stepNext} = ({intervalReg, stepReg} & ~wrMask) | (dataIn & wrMask);
    end

    case (stateReg)
      IDLE: begin
        if (commitReq) begin
          targetNext = freqStageReg;
          if ((stepReg == 16'h0000) || (freqStageReg == freqLiveReg)) begin
            // Nothing to ramp: land on the target right away.
            freqLiveNext   = freqStageReg;
            doneStickyNext = 1'b1;
          end else begin
            stateNext       = SLEW;
            intervalCntNext = intervalReg;
          end
        end
      end
      SLEW: begin
        if (abortReq) begin
          stateNext = IDLE;
        end else if (commitReq) begin
          // Retarget from wherever live currently is; restart the interval.
          targetNext      = freqStageReg;
          intervalCntNext = intervalReg;
        end else if (intervalCntReg != 16'h0000) begin
          intervalCntNext = intervalCntReg - 16'h0001;
        end else begin
          freqLiveNext    = slewValue;
          intervalCntNext = intervalReg;
          if (slewValue == targetReg) begin
            stateNext      = IDLE;
            doneStickyNext = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
`else
    if (commitReq) begin
      freqLiveNext   = freqStageReg;
      doneStickyNext = 1'b1;
    end
`endif

    // Registered so the pulse lines up with the new live values.
    strobeNext = (freqLiveNext != freqLiveReg) ||
                 (gainLiveNext != gainLiveReg) ||
                 (divLiveNext  != divLiveReg);
  end

  always_ff @(posedge busClk) begin
    if (reset) begin
      freqStageReg  <= FREQ_RESET;
      gainStageReg  <= 5'h00;
      divStageReg   <= DIV_RESET;
      freqLiveReg   <= FREQ_RESET;
      gainLiveReg   <= 5'h00;
      divLiveReg    <= DIV_RESET;
      doneStickyReg <= 1'b0;
      strobeReg     <= 1'b0;
`ifdef DPLL_FREQ_SLEW_EN
      stateReg       <= IDLE;
      stepReg        <= 16'h0000;
      intervalReg    <= 16'h0000;
      intervalCntReg <= 16'h0000;
      targetReg      <= FREQ_RESET;
`endif
    end else begin
      freqStageReg  <= freqStageNext;
      gainStageReg  <= gainStageNext;
      divStageReg   <= divStageNext;
      freqLiveReg   <= freqLiveNext;
      gainLiveReg   <= gainLiveNext;
      divLiveReg    <= divLiveNext;
      doneStickyReg <= doneStickyNext;
      strobeReg     <= strobeNext;
`ifdef DPLL_FREQ_SLEW_EN
      stateReg       <= stateNext;
      stepReg        <= stepNext;
      intervalReg    <= intervalNext;
      intervalCntReg <= intervalCntNext;
      targetReg      <= targetNext;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs and read mux
  // --------------------------------------------------------------------------
  assign centerFreq      = freqLiveReg;
  assign loopGain        = gainLiveReg;
  assign feedbackDivider = divLiveReg;
  assign configStrobe    = strobeReg;

  always_comb begin
    dataOut = 32'h0000_0000;
    if (blockSel) begin
      case (offset)
        3'd0: dataOut = freqStageReg;
        3'd1: dataOut = {8'h00, divStageReg, 11'h000, gainStageReg};
`ifdef DPLL_FREQ_SLEW_EN
        3'd3: dataOut = {intervalReg, stepReg};
`endif
        3'd4: dataOut = {29'h0000_0000, doneStickyReg, slewBusy, 1'b0};
        3'd5: dataOut = freqLiveReg;
        default: dataOut = 32'h0000_0000;
      endcase
    end
  end

endmodule

// File: tb/tb_dpll_config_slew.sv
// Directed testbench for dpll_config_slew. Inputs are driven at the falling
// edge and outputs sampled at the falling edge, half a period away from the
// active rising edge. Slew scenarios run only when DPLL_FREQ_SLEW_EN is
// defined; otherwise the immediate-apply behaviour is checked.
module tb_dpll_config_slew;

  logic        busClk;
  logic        reset;
  logic [12:0] addr;
  logic [31:0] dataIn;
  logic        wr0, wr1, wr2, wr3;
  logic [31:0] dataOut;
  logic [31:0] centerFreq;
  logic [4:0]  loopGain;
  logic [7:0]  feedbackDivider;
  logic        slewBusy;
  logic        configStrobe;

  int assertCount = 0;
  int failCount   = 0;

  dpll_config_slew dut (
    .busClk          (busClk),
    .reset           (reset),
    .addr            (addr),
    .dataIn          (dataIn),
    .wr0             (wr0),
    .wr1             (wr1),
    .wr2             (wr2),
    .wr3             (wr3),
    .dataOut         (dataOut),
    .centerFreq      (centerFreq),
    .loopGain        (loopGain),
    .feedbackDivider (feedbackDivider),
    .slewBusy        (slewBusy),
    .configStrobe    (configStrobe)
  );

  initial busClk = 1'b0;
  always #5 busClk = ~busClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the write is captured on the next rising edge
  // and the task returns at the falling edge after it.
  task automatic busWrite(input logic [2:0] off, input logic [31:0] data, input logic [3:0] lanes);
    addr   = {8'h00, off, 2'b00};
    dataIn = data;
    {wr3, wr2, wr1, wr0} = lanes;
    $display("write off=%0d data=%h lanes=%b", off, data, lanes);
    @(negedge busClk);
    {wr3, wr2, wr1, wr0} = 4'b0000;
  endtask

  task automatic busRead(input logic [12:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    #1;
    $display("read  addr=%h data=%h", a, dataOut);
    check(tag, dataOut, exp);
  endtask

  function automatic logic [12:0] regAddr(input logic [2:0] off);
    return {8'h00, off, 2'b00};
  endfunction

  initial begin
    reset  = 1'b1;
    addr   = 13'h0;
    dataIn = 32'h0;
    {wr3, wr2, wr1, wr0} = 4'b0000;
    repeat (3) @(negedge busClk);
    reset = 1'b0;
    @(negedge busClk);

    // ---------------- reset state ----------------
    busRead(regAddr(3'd0), 32'h0000_0000, "rst_freq_stage");
    busRead(regAddr(3'd1), 32'h0001_0000, "rst_gain_stage");
    busRead(regAddr(3'd2), 32'h0000_0000, "rst_control_read");
    busRead(regAddr(3'd3), 32'h0000_0000, "rst_slew_cfg");
    busRead(regAddr(3'd4), 32'h0000_0000, "rst_status");
    busRead(regAddr(3'd5), 32'h0000_0000, "rst_live_freq");
    busRead(regAddr(3'd6), 32'h0000_0000, "rst_off6");
    check("rst_centerFreq", centerFreq, 32'h0);
    check("rst_loopGain", 32'(loopGain), 32'h0);
    check("rst_divider", 32'(feedbackDivider), 32'h1);
    check("rst_slewBusy", 32'(slewBusy), 32'h0);
    check("rst_strobe", 32'(configStrobe), 32'h0);

    // ---------------- staging and immediate commit ----------------
    @(negedge busClk);
    busWrite(3'd0, 32'h1000_0000, 4'b1111);
    busWrite(3'd1, 32'h0010_000A, 4'b0101);
    busRead(regAddr(3'd0), 32'h1000_0000, "stage_freq_rb");
    busRead(regAddr(3'd1), 32'h0010_000A, "stage_gain_rb");
    busRead(13'h0020, 32'h0000_0000, "unselected_read");
    busRead(regAddr(3'd7), 32'h0000_0000, "off7_read");
    check("stage_no_live_freq", centerFreq, 32'h0);
    check("stage_no_live_gain", 32'(loopGain), 32'h0);
    @(negedge busClk);
    busWrite(3'd2, 32'h0000_0001, 4'b0001);
    check("commit_freq", centerFreq, 32'h1000_0000);
    check("commit_gain", 32'(loopGain), 32'h0A);
    check("commit_div", 32'(feedbackDivider), 32'h10);
    check("commit_strobe", 32'(configStrobe), 32'h1);
    check("commit_busy", 32'(slewBusy), 32'h0);
    @(negedge busClk);
    check("commit_strobe_single", 32'(configStrobe), 32'h0);

    // Recommit with identical staging: nothing changes, no strobe.
    busWrite(3'd2, 32'h0000_0001, 4'b0001);
    check("recommit_no_strobe", 32'(configStrobe), 32'h0);

    // Single-lane write only touches bits [15:8].
    busWrite(3'd0, 32'hAABB_CCDD, 4'b0010);
    busRead(regAddr(3'd0), 32'h1000_CC00, "byte_lane_freq");

`ifdef DPLL_FREQ_SLEW_EN
    // ---------------- ramp 0 -> 0x100, step 0x40, interval 2 ----------------
    @(negedge busClk);
    busWrite(3'd0, 32'h0000_0000, 4'b1111);
    busWrite(3'd2, 32'h0000_0001, 4'b0001);
    check("slew_pre_live0", centerFreq, 32'h0);
    busWrite(3'd3, 32'h0002_0040, 4'b1111);
    busRead(regAddr(3'd3), 32'h0002_0040, "slew_cfg_rb");
    @(negedge busClk);
    busWrite(3'd0, 32'h0000_0100, 4'b1111);
    busWrite(3'd2, 32'h0000_0001, 4'b0001);
    check("ramp_start_busy", 32'(slewBusy), 32'h1);
    check("ramp_start_live", centerFreq, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      repeat (2) @(negedge busClk);
      check($sformatf("ramp_hold_%0d", k), centerFreq, 32'(32'h40 * (k - 1)));
      @(negedge busClk);
      check($sformatf("ramp_step_%0d", k), centerFreq, 32'(32'h40 * k));
      check($sformatf("ramp_strobe_%0d", k), 32'(configStrobe), 32'h1);
      check($sformatf("ramp_busy_%0d", k), 32'(slewBusy), (k < 4) ? 32'h1 : 32'h0);
    end
    busRead(regAddr(3'd4), 32'h0000_0004, "ramp_status_done");
    busRead(regAddr(3'd5), 32'h0000_0100, "ramp_live_rb");

    // ---------------- 0x100 -> 0xF0 lands exactly ----------------
    @(negedge busClk);
    busWrite(3'd0, 32'h0000_00F0, 4'b1111);
    busWrite(3'd2, 32'h0000_0001, 4'b0001);
    busRead(regAddr(3'd4), 32'h0000_0002, "down_status_busy_done_clr");
    @(negedge busClk);
    @(negedge busClk);
    check("down_hold", centerFreq, 32'h0000_0100);
    @(negedge busClk);
    check("down_exact", centerFreq, 32'h0000_00F0);
    check("down_busy", 32'(slewBusy), 32'h0);

    // ---------------- clamp at top, no wrap ----------------
    busWrite(3'd3, 32'h0000_0000, 4'b1111);
    busWrite(3'd0, 32'hFFFF_FFF0, 4'b1111);
    busWrite(3'd2, 32'h0000_0001, 4'b0001);
    check("top_preload", centerFreq, 32'hFFFF_FFF0);
    busWrite(3'd3, 32'h0000_0040, 4'b1111);
    busWrite(3'd0, 32'hFFFF_FFFF, 4'b1111);
    busWrite(3'd2, 32'h0000_0001, 4'b0001);
    check("top_busy", 32'(slewBusy), 32'h1);
    @(negedge busClk);
    check("top_clamp", centerFreq, 32'hFFFF_FFFF);
    check("top_done", 32'(slewBusy), 32'h0);

    // ---------------- mid-slew retarget and abort ----------------
    busWrite(3'd3, 32'h0000_0000, 4'b1111);
    busWrite(3'd0, 32'h0000_0000, 4'b1111);
    busWrite(3'd2, 32'h0000_0001, 4'b0001);
    busWrite(3'd3, 32'h0002_0040, 4'b1111);
    busWrite(3'd0, 32'h0000_0100, 4'b1111);
    busWrite(3'd2, 32'h0000_0001, 4'b0001);
    repeat (6) @(negedge busClk);
    check("rev_live_80", centerFreq, 32'h0000_0080);
    busWrite(3'd0, 32'h0000_0000, 4'b1111);
    busWrite(3'd2, 32'h0000_0001, 4'b0001);
    check("rev_commit_live", centerFreq, 32'h0000_0080);
    check("rev_commit_busy", 32'(slewBusy), 32'h1);
    repeat (2) @(negedge busClk);
    check("rev_hold", centerFreq, 32'h0000_0080);
    @(negedge busClk);
    check("rev_down_40", centerFreq, 32'h0000_0040);
    busWrite(3'd2, 32'h0000_0002, 4'b0001);
    check("abort_live", centerFreq, 32'h0000_0040);
    check("abort_busy", 32'(slewBusy), 32'h0);
    repeat (5) @(negedge busClk);
    check("abort_frozen", centerFreq, 32'h0000_0040);
    busRead(regAddr(3'd4), 32'h0000_0000, "abort_status");

    // ---------------- commit+abort together does nothing ----------------
    @(negedge busClk);
    busWrite(3'd1, 32'h0010_001F, 4'b0101);
    busWrite(3'd0, 32'h0000_1234, 4'b1111);
    busWrite(3'd2, 32'h0000_0003, 4'b0001);
    check("both_live", centerFreq, 32'h0000_0040);
    check("both_gain", 32'(loopGain), 32'h0A);
    check("both_strobe", 32'(configStrobe), 32'h0);
    check("both_busy", 32'(slewBusy), 32'h0);

    // ---------------- reset during SLEW ----------------
    busWrite(3'd0, 32'h0000_0100, 4'b1111);
    busWrite(3'd2, 32'h0000_0001, 4'b0001);
    repeat (3) @(negedge busClk);
    check("rstslew_live_80", centerFreq, 32'h0000_0080);
    check("rstslew_busy_pre", 32'(slewBusy), 32'h1);
    reset = 1'b1;
    @(negedge busClk);
    check("rstslew_live", centerFreq, 32'h0);
    check("rstslew_busy", 32'(slewBusy), 32'h0);
    check("rstslew_gain", 32'(loopGain), 32'h0);
    check("rstslew_div", 32'(feedbackDivider), 32'h1);
    reset = 1'b0;
    busRead(regAddr(3'd3), 32'h0000_0000, "rstslew_cfg");
    busRead(regAddr(3'd0), 32'h0000_0000, "rstslew_stage");
`else
    // ---------------- immediate apply without slew engine ----------------
    @(negedge busClk);
    busWrite(3'd3, 32'h0002_0040, 4'b1111);
    busRead(regAddr(3'd3), 32'h0000_0000, "noslew_cfg_read");
    @(negedge busClk);
    busWrite(3'd0, 32'h0000_0000, 4'b1111);
    busWrite(3'd2, 32'h0000_0001, 4'b0001);
    check("noslew_live0", centerFreq, 32'h0);
    busWrite(3'd0, 32'h0000_0100, 4'b1111);
    busWrite(3'd2, 32'h0000_0001, 4'b0001);
    check("noslew_one_edge", centerFreq, 32'h0000_0100);
    check("noslew_busy", 32'(slewBusy), 32'h0);
    check("noslew_strobe", 32'(configStrobe), 32'h1);
    busRead(regAddr(3'd4), 32'h0000_0004, "noslew_status_done");
    @(negedge busClk);
    busWrite(3'd0, 32'h0000_0200, 4'b1111);
    busWrite(3'd2, 32'h0000_0003, 4'b0001);
    check("noslew_both_no_change", centerFreq, 32'h0000_0100);
    reset = 1'b1;
    @(negedge busClk);
    check("noslew_reset_live", centerFreq, 32'h0);
    check("noslew_reset_div", 32'(feedbackDivider), 32'h1);
    reset = 1'b0;
    busRead(regAddr(3'd4), 32'h0000_0000, "noslew_reset_status");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/dpll_config_slew.md
Name: dpll_config_slew

Overview:
- busClk-domain register bank that feeds the digital PLL its quasi-static controls: centerFreq, loopGain and feedbackDivider.
- Processor writes go to staging registers; a commit makes them live atomically.
- With slew enabled, the live centerFreq ramps toward the committed target in programmable steps, so the loop does not unlock on large retunes.
- Outputs drive the PLL's centerFreq, loopGain and feedbackDivider inputs directly.

Parameters:
- SPACE_BASE, 8'h00, block selected when addr[12:5] == SPACE_BASE.
- FREQ_RESET, 32'h0000_0000, reset value of staging and live centerFreq.
- DIV_RESET, 8'h01, reset value of staging and live feedbackDivider.

Ports:
- busClk  in  1  clock for all logic.
- reset  in  1  synchronous, active-high.
- addr  in  13  bus address; offset = addr[4:2].
- dataIn  in  32  write data.
- wr0, wr1, wr2, wr3  in  1 each  byte-lane write strobes for bits [7:0], [15:8], [23:16], [31:24].
- dataOut  out  32  combinational read data.
- centerFreq  out  32  live NCO center frequency.
- loopGain  out  5  live loop gain.
- feedbackDivider  out  8  live feedback divider.
- slewBusy  out  1  high while ramping.
- configStrobe  out  1  one-cycle pulse whenever any live output changes.

Behaviour:
- Reset domain: reset is synchronous, active-high; clock is busClk.
- Register map (offset):
  - 0 FREQ_STAGE: rw, byte-writable.
  - 1 GAIN_STAGE: rw; loopGain in [4:0] via wr0, feedbackDivider in [23:16] via wr2.
  - 2 CONTROL: wo, wr0 only; bit0 = commit, bit1 = abort.
  - 3 SLEW_CFG: rw, byte-writable; step in [15:0], interval in [31:16].
  - 4 STATUS: ro; {29'b0, doneSticky, slewBusy, 1'b0}; a read has no side effect.
  - 5 LIVE_FREQ: ro; returns live centerFreq.
- dataOut = 32'h0 when the block is not selected or at offsets 6-7. Reads of CONTROL return 0.
- Reset values:
  - staging and live centerFreq = FREQ_RESET.
  - loopGain = 0.
  - feedbackDivider = DIV_RESET.
  - step = 0, interval = 0.
  - state = IDLE; slewBusy = 0; configStrobe = 0; doneSticky = 0.
- Commit (CONTROL write, bit0 = 1, bit1 = 0):
  - loopGain and feedbackDivider are copied from staging on the next edge.
  - target <= staged freq.
  - configStrobe pulses on that edge if any live value changed.
- State machine IDLE / SLEW:
  - IDLE + commit: if step == 0 or target == live, live centerFreq <= target on the same edge and stay in IDLE. Otherwise go to SLEW, load intervalCnt <= interval, and set slewBusy = 1.
  - SLEW, each cycle: if intervalCnt != 0, decrement it. If intervalCnt == 0, move live toward target by step, then reload intervalCnt. One update occurs every interval+1 cycles; interval = 0 gives a step every cycle.
  - Step arithmetic is an unsigned 32-bit comparison. If |target - live| <= step, live <= target exactly (no overshoot, no wrap past 0 or 2^32-1). Otherwise live +/- step.
  - When live reaches target: go to IDLE, slewBusy <= 0, doneSticky <= 1.
  - Each live freq update pulses configStrobe.
  - Commit during SLEW: target is reloaded, ramping continues from the current live value, and intervalCnt restarts at interval. Gains apply immediately.
  - Abort (bit1): go to IDLE, live frozen at its current value, doneSticky unchanged. If bit0 and bit1 are set together, abort wins and nothing is committed.
- doneSticky is cleared by the next commit.
- Staging and SLEW_CFG writes never affect live outputs until a commit. A SLEW_CFG write during SLEW takes effect at the next interval reload.
- Reset mid-SLEW: all registers return to reset values on that edge.

Optional Feature:
- Macro DPLL_FREQ_SLEW_EN.
- Defined: slew engine as described.
- Undefined:
  - Every commit applies centerFreq immediately.
  - slewBusy tied 0; doneSticky set on each commit.
  - SLEW_CFG reads 0 and writes are ignored.
  - No SLEW state is synthesized.

Test Plan:
- Reset, then read all offsets -> FREQ 0, GAIN {8'h0, 8'h01, 11'h0, 5'h0}, STATUS 0, LIVE 0, centerFreq 0, feedbackDivider 1.
- Stage freq 32'h1000_0000, gain 5'h0A, div 8'h10, step 0, then commit -> all three live outputs update one edge after the write, one configStrobe pulse, slewBusy stays 0.
- Live 0, target 32'h0000_0100, step 16'h0040, interval 2, commit -> live steps 0x40, 0x80, 0xC0, 0x100, one step every 3 cycles; slewBusy falls on the 0x100 edge; STATUS bit2 = 1.
- Live 32'h0000_0100, target 32'h0000_00F0, step 16'h0040 -> a single step lands exactly on 0xF0 with no underflow. Live 32'hFFFF_FFF0 to target 32'hFFFF_FFFF, step 0x40 -> clamps to 32'hFFFF_FFFF with no wrap.
- Mid-slew commit of a new target 32'h0 while live = 0x80 ramping up -> direction reverses from 0x80. Abort at live 0x40 -> live freezes at 0x40, slewBusy = 0. Commit+abort in the same write -> no change.
- Reset asserted during SLEW -> next edge live = FREQ_RESET, slewBusy = 0. Build without DPLL_FREQ_SLEW_EN -> the 0 to 0x100 commit applies in one edge.
